// File: rtl/alu_request_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, with a response channel.
// Optional macro ALU_RANGE_CHECK_EN rejects multiply/divide operands the 4-bit ALU units cannot handle.
module alu_request_arbiter #(
  parameter int DATA_W        = 8,
  parameter int OP_W          = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [DATA_W-1:0] alu_operand_1,
  output logic [DATA_W-1:0] alu_operand_2,
  output logic [OP_W-1:0]   alu_operator,
  input  logic [DATA_W-1:0] alu_answer1,
  input  logic [DATA_W-1:0] alu_answer2,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_ans1,
  output logic [DATA_W-1:0] rsp_ans2,
  output logic              rsp_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  localparam logic [OP_W-1:0] OP_MUL           = OP_W'(5);
  localparam logic [OP_W-1:0] OP_DIV           = OP_W'(6);
  localparam logic [OP_W-1:0] OP_FIRST_ILLEGAL = OP_W'(7);
  localparam logic [3:0]      SETTLE_INIT      = 4'(SETTLE_CYCLES - 1);

  logic [1:0]        state;
  logic              last_grant;
  logic [3:0]        settle_cnt;
  logic              grant;
  logic              accept;
  logic              reject;
  logic [OP_W-1:0]   sel_op;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;

  // On contention the requester that was not served last wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else if (req1_valid)          grant = 1'b1;
  end

  assign req0_ready = (state == IDLE) && req0_valid && !grant;
  assign req1_ready = (state == IDLE) && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;

  assign sel_op = grant ? req1_op : req0_op;
  assign sel_a  = grant ? req1_a  : req0_a;
  assign sel_b  = grant ? req1_b  : req0_b;

`ifdef ALU_RANGE_CHECK_EN
  logic a_wide;
  logic b_wide;
  assign a_wide = |sel_a[DATA_W-1:4];
  assign b_wide = |sel_b[DATA_W-1:4];
  assign reject = (sel_op >= OP_FIRST_ILLEGAL)
               || ((sel_op == OP_MUL) && (a_wide || b_wide))
               || ((sel_op == OP_DIV) && (a_wide || b_wide || (sel_b == '0)));
`else
  assign reject = (sel_op >= OP_FIRST_ILLEGAL);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      settle_cnt    <= 4'd0;
      alu_operand_1 <= '0;
      alu_operand_2 <= '0;
      alu_operator  <= '0;
      rsp_valid     <= 1'b0;
      rsp_id        <= 1'b0;
      rsp_ans1      <= '0;
      rsp_ans2      <= '0;
      rsp_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rsp_id     <= grant;
            last_grant <= grant;
            // Rejected commands never reach the ALU, so the holding registers keep the last issue.
            if (reject) begin
              rsp_err   <= 1'b1;
              rsp_ans1  <= '0;
              rsp_ans2  <= '0;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              alu_operator  <= sel_op;
              alu_operand_1 <= sel_a;
              alu_operand_2 <= sel_b;
              settle_cnt    <= SETTLE_INIT;
              state         <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (settle_cnt == 4'd0) begin
            rsp_ans1  <= alu_answer1;
            rsp_ans2  <= alu_answer2;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_request_arbiter.sv
// Bench for alu_request_arbiter: a transaction-level model checked every cycle, plus directed literal checks.
// A second instance with a 4-cycle settle interval covers reset in the middle of an issue.
module tb_alu_request_arbiter;

  localparam int SETTLE = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_op, req1_op, alu_operator;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [7:0] alu_operand_1, alu_operand_2, alu_answer1, alu_answer2;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [7:0] rsp_ans1, rsp_ans2;

  logic       s_rst_n;
  logic       s_req0_valid, s_req0_ready, s_req1_valid, s_req1_ready;
  logic [3:0] s_req0_op, s_req1_op, s_alu_operator;
  logic [7:0] s_req0_a, s_req0_b, s_req1_a, s_req1_b;
  logic [7:0] s_alu_operand_1, s_alu_operand_2, s_alu_answer1, s_alu_answer2;
  logic       s_rsp_valid, s_rsp_ready, s_rsp_id, s_rsp_err;
  logic [7:0] s_rsp_ans1, s_rsp_ans2;

  int checks = 0;
  int errors = 0;
  bit model_on = 1'b0;

  always #5 clk = ~clk;

  alu_request_arbiter #(.DATA_W(8), .OP_W(4), .SETTLE_CYCLES(SETTLE)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_operand_1(alu_operand_1), .alu_operand_2(alu_operand_2), .alu_operator(alu_operator),
    .alu_answer1(alu_answer1), .alu_answer2(alu_answer2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_ans1(rsp_ans1), .rsp_ans2(rsp_ans2), .rsp_err(rsp_err)
  );

  alu_request_arbiter #(.DATA_W(8), .OP_W(4), .SETTLE_CYCLES(4)) u_dut_slow (
    .clk(clk), .rst_n(s_rst_n),
    .req0_valid(s_req0_valid), .req0_ready(s_req0_ready), .req0_op(s_req0_op), .req0_a(s_req0_a), .req0_b(s_req0_b),
    .req1_valid(s_req1_valid), .req1_ready(s_req1_ready), .req1_op(s_req1_op), .req1_a(s_req1_a), .req1_b(s_req1_b),
    .alu_operand_1(s_alu_operand_1), .alu_operand_2(s_alu_operand_2), .alu_operator(s_alu_operator),
    .alu_answer1(s_alu_answer1), .alu_answer2(s_alu_answer2),
    .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_id(s_rsp_id),
    .rsp_ans1(s_rsp_ans1), .rsp_ans2(s_rsp_ans2), .rsp_err(s_rsp_err)
  );

  // Stand-in ALU returning {answer1, answer2}; illegal codes return a marker that must never be captured.
  function automatic logic [15:0] alu_func(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] r;
    logic [8:0]  s;
    r = '0;
    s = {1'b0, a} + {1'b0, b};
    case (op)
      4'd0: r[15:8] = (a == b) ? 8'd1 : 8'd0;
      4'd1: r[15:8] = a & b;
      4'd2: r[15:8] = a | b;
      4'd3: r = {s[7:0], 7'd0, s[8]};
      4'd4: r = {a - b, (a < b) ? 8'd1 : 8'd0};
      4'd5: r[15:8] = a[3:0] * b[3:0];
      4'd6: if (b != 8'd0) r = {a / b, a % b};
      default: r = 16'hA5A5;
    endcase
    return r;
  endfunction

  function automatic logic rejected(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic rj;
    rj = (op >= 4'd7);
`ifdef ALU_RANGE_CHECK_EN
    if (op == 4'd5 && (a[7:4] != 4'd0 || b[7:4] != 4'd0)) rj = 1'b1;
    if (op == 4'd6 && (b == 8'd0 || a[7:4] != 4'd0 || b[7:4] != 4'd0)) rj = 1'b1;
`else
    if (a == 8'hxx || b == 8'hxx) rj = rj;
`endif
    return rj;
  endfunction

  assign {alu_answer1, alu_answer2}     = alu_func(alu_operator, alu_operand_1, alu_operand_2);
  assign {s_alu_answer1, s_alu_answer2} = alu_func(s_alu_operator, s_alu_operand_1, s_alu_operand_2);

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: the block is either free or owns one command whose response becomes due at a known edge.
  logic       m_busy = 1'b0, m_last = 1'b1, m_pend = 1'b0;
  int         m_edge = 0, m_due = 0;
  logic       m_id = 1'b0, m_err = 1'b0;
  logic [7:0] m_a1 = '0, m_a2 = '0, m_opa = '0, m_opb = '0;
  logic [3:0] m_op = '0;

  task automatic exp_ready(output logic r0, output logic r1);
    r0 = !m_busy && req0_valid && (!req1_valid || m_last == 1'b1);
    r1 = !m_busy && req1_valid && (!req0_valid || m_last == 1'b0);
  endtask

  always @(posedge clk) begin : model
    logic r0, r1, was_valid, n;
    logic [3:0] op;
    logic [7:0] a, b;
    exp_ready(r0, r1);
    was_valid = m_pend && (m_edge >= m_due);
    m_edge = m_edge + 1;
    if (!rst_n) begin
      m_busy = 1'b0; m_last = 1'b1; m_pend = 1'b0;
      m_op = '0; m_opa = '0; m_opb = '0;
    end else if (was_valid && rsp_ready) begin
      m_pend = 1'b0; m_busy = 1'b0;
    end else if (r0 || r1) begin
      n  = r1;
      op = n ? req1_op : req0_op;
      a  = n ? req1_a  : req0_a;
      b  = n ? req1_b  : req0_b;
      m_last = n; m_id = n; m_busy = 1'b1; m_pend = 1'b1;
      if (rejected(op, a, b)) begin
        m_err = 1'b1; m_a1 = '0; m_a2 = '0; m_due = m_edge;
      end else begin
        m_op = op; m_opa = a; m_opb = b;
        {m_a1, m_a2} = alu_func(op, a, b);
        m_err = 1'b0; m_due = m_edge + SETTLE;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic r0, r1, mv;
    if (model_on) begin
      exp_ready(r0, r1);
      mv = m_pend && (m_edge >= m_due);
      checkOutput("req0_ready", req0_ready, r0);
      checkOutput("req1_ready", req1_ready, r1);
      checkOutput("rsp_valid", rsp_valid, mv);
      if (mv) begin
        checkOutput("rsp_id", rsp_id, m_id);
        checkOutput("rsp_ans1", rsp_ans1, m_a1);
        checkOutput("rsp_ans2", rsp_ans2, m_a2);
        checkOutput("rsp_err", rsp_err, m_err);
      end
      checkOutput("alu_operator", alu_operator, m_op);
      checkOutput("alu_operand_1", alu_operand_1, m_opa);
      checkOutput("alu_operand_2", alu_operand_2, m_opb);
    end
  end

  task automatic applyStimulus(input int n, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    if (n == 0) begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
    else        begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
  endtask

  task automatic await_ready(input int n, input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if ((n == 0) ? req0_ready : req1_ready) begin seen = 1'b1; break; end
    end
    checkOutput({name, " accepted"}, seen, 1);
    @(posedge clk); #1;
    if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic await_rsp(input string name, input int exp_lat, input logic exp_id,
                           input logic [7:0] e1, input logic [7:0] e2, input logic eerr);
    int lat = 0;
    bit seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rsp_valid) begin seen = 1'b1; break; end
      lat++;
    end
    checkOutput({name, " rsp seen"}, seen, 1);
    checkOutput({name, " latency"}, lat, exp_lat);
    checkOutput({name, " id"}, rsp_id, exp_id);
    checkOutput({name, " ans1"}, rsp_ans1, e1);
    checkOutput({name, " ans2"}, rsp_ans2, e2);
    checkOutput({name, " err"}, rsp_err, eerr);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    bit seen;
    rst_n = 1'b0; s_rst_n = 1'b0;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
    s_req0_valid = 1'b0; s_req0_op = '0; s_req0_a = '0; s_req0_b = '0;
    s_req1_valid = 1'b0; s_req1_op = '0; s_req1_a = '0; s_req1_b = '0;
    rsp_ready = 1'b1; s_rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("reset rsp_valid", rsp_valid, 0);
    checkOutput("reset rsp_id", rsp_id, 0);
    checkOutput("reset rsp_ans1", rsp_ans1, 0);
    checkOutput("reset rsp_ans2", rsp_ans2, 0);
    checkOutput("reset rsp_err", rsp_err, 0);
    checkOutput("reset alu_operator", alu_operator, 0);
    checkOutput("reset alu_operand_1", alu_operand_1, 0);
    checkOutput("slow reset rsp_valid", s_rsp_valid, 0);
    model_on = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; s_rst_n = 1'b1;

    $display("[TB] add with carry");
    applyStimulus(0, 4'd3, 8'd200, 8'd100);
    await_ready(0, "add");
    await_rsp("add", 1, 1'b0, 8'd44, 8'd1, 1'b0);

    $display("[TB] simultaneous requests after reset");
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(0, 4'd0, 8'd5, 8'd5);
    applyStimulus(1, 4'd4, 8'd3, 8'd5);
    await_ready(0, "pair0");
    await_rsp("pair0", 1, 1'b0, 8'd1, 8'd0, 1'b0);
    await_ready(1, "pair1");
    await_rsp("pair1", 1, 1'b1, 8'd254, 8'd1, 1'b0);
    applyStimulus(0, 4'd3, 8'd7, 8'd8);
    applyStimulus(1, 4'd4, 8'd9, 8'd9);
    await_ready(0, "pair2");
    await_rsp("pair2", 1, 1'b0, 8'd15, 8'd0, 1'b0);
    await_ready(1, "pair3");
    await_rsp("pair3", 1, 1'b1, 8'd0, 8'd0, 1'b0);

    $display("[TB] divide");
    applyStimulus(1, 4'd6, 8'd13, 8'd4);
    await_ready(1, "div");
    await_rsp("div", 1, 1'b1, 8'd3, 8'd1, 1'b0);
    applyStimulus(1, 4'd6, 8'd13, 8'd0);
    await_ready(1, "div0");
`ifdef ALU_RANGE_CHECK_EN
    await_rsp("div0", 0, 1'b1, 8'd0, 8'd0, 1'b1);
    checkOutput("div0 operand_2 kept", alu_operand_2, 4);
`else
    await_rsp("div0", 1, 1'b1, 8'd0, 8'd0, 1'b0);
`endif
    checkOutput("div0 operator", alu_operator, 6);

    $display("[TB] illegal operator");
    applyStimulus(0, 4'd9, 8'd77, 8'd88);
    await_ready(0, "illegal");
    await_rsp("illegal", 0, 1'b0, 8'd0, 8'd0, 1'b1);
    checkOutput("illegal operator kept", alu_operator, 6);
    checkOutput("illegal operand_1 kept", alu_operand_1, 13);

    $display("[TB] response back-pressure");
    rsp_ready = 1'b0;
    applyStimulus(0, 4'd3, 8'd1, 8'd2);
    await_ready(0, "stall");
    applyStimulus(1, 4'd4, 8'd10, 8'd3);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rsp_valid) begin seen = 1'b1; break; end
    end
    checkOutput("stall rsp seen", seen, 1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      checkOutput("stall rsp_valid", rsp_valid, 1);
      checkOutput("stall rsp_ans1", rsp_ans1, 3);
      checkOutput("stall rsp_id", rsp_id, 0);
      checkOutput("stall req1_ready", req1_ready, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("post-stall req1_ready", req1_ready, 1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    await_rsp("post-stall", 1, 1'b1, 8'd7, 8'd0, 1'b0);

    $display("[TB] reset during issue, settle 4");
    s_req0_valid = 1'b1; s_req0_op = 4'd3; s_req0_a = 8'd10; s_req0_b = 8'd20;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (s_req0_ready) begin seen = 1'b1; break; end
    end
    checkOutput("slow accept", seen, 1);
    @(posedge clk); #1;
    s_req0_valid = 1'b0;
    @(negedge clk);
    checkOutput("slow issue rsp_valid", s_rsp_valid, 0);
    checkOutput("slow issue operand_1", s_alu_operand_1, 10);
    @(posedge clk);
    @(negedge clk);
    s_rst_n = 1'b0;
    @(posedge clk); #1;
    s_rst_n = 1'b1;
    @(negedge clk);
    checkOutput("slow post-reset rsp_valid", s_rsp_valid, 0);
    checkOutput("slow post-reset rsp_ans1", s_rsp_ans1, 0);
    checkOutput("slow post-reset rsp_err", s_rsp_err, 0);
    checkOutput("slow post-reset operator", s_alu_operator, 0);
    checkOutput("slow post-reset operand_1", s_alu_operand_1, 0);
    checkOutput("slow post-reset operand_2", s_alu_operand_2, 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput("slow dropped rsp_valid", s_rsp_valid, 0);
    end
    @(posedge clk); #1;
    s_req1_valid = 1'b1; s_req1_op = 4'd4; s_req1_a = 8'd9; s_req1_b = 8'd4;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (s_req1_ready) begin seen = 1'b1; break; end
    end
    checkOutput("slow second accept", seen, 1);
    @(posedge clk); #1;
    s_req1_valid = 1'b0;
    lat = 0; seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (s_rsp_valid) begin seen = 1'b1; break; end
      lat++;
    end
    checkOutput("slow rsp seen", seen, 1);
    checkOutput("slow latency", lat, 4);
    checkOutput("slow rsp_id", s_rsp_id, 1);
    checkOutput("slow rsp_ans1", s_rsp_ans1, 5);
    checkOutput("slow rsp_ans2", s_rsp_ans2, 0);
    checkOutput("slow rsp_err", s_rsp_err, 0);
    @(posedge clk); #1;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
